// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP-stage state encodings, defaults and helpers
package dsp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam int DEF_MAX_LOG2 = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - 2-entry valid/ready FIFO with registered storage outputs
module skid_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    logic [W-1:0] r_mem [0:1];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_cnt;
    logic         w_do_pop;
    logic         w_do_push;

    assign full      = (r_cnt == 2'd2);
    assign empty     = (r_cnt == 2'd0);
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

endmodule

// File: rtl/minmax_decimator.sv
// rtl/minmax_decimator.sv - windowed min/max peak-detect decimator with skid FIFO output
// Optional window mean output enabled by MINMAX_DECIM_AVG_EN.
module minmax_decimator
    import dsp_pkg::*;
#(
    parameter int   PRECISION = 16,
    parameter int   MAX_LOG2  = DEF_MAX_LOG2,
    localparam int  LW        = clog2(MAX_LOG2 + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [LW-1:0]               decim_log2,
    input  logic                        in_valid,
    input  logic signed [PRECISION-1:0] x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [PRECISION-1:0] y_min,
    output logic signed [PRECISION-1:0] y_max,
`ifdef MINMAX_DECIM_AVG_EN
    output logic signed [PRECISION-1:0] y_avg,
`endif
    output logic                        overrun,
    input  logic                        clear_overrun
);

    localparam int             CW    = MAX_LOG2 + 1;
    localparam logic [LW-1:0]  MAX_L = LW'(MAX_LOG2);
`ifdef MINMAX_DECIM_AVG_EN
    localparam int             SW    = PRECISION + MAX_LOG2;
    localparam int             FW    = 3 * PRECISION;
`else
    localparam int             FW    = 2 * PRECISION;
`endif

    state_t                        r_state;
    state_t                        w_state_nx;
    logic [CW-1:0]                 r_cnt;
    logic [LW-1:0]                 r_len;
    logic signed [PRECISION-1:0]   r_min;
    logic signed [PRECISION-1:0]   r_max;
    logic                          r_overrun;

    logic                          w_accept;
    logic                          w_first;
    logic [LW-1:0]                 w_len_in;
    logic [LW-1:0]                 w_len;
    logic [CW-1:0]                 w_cnt_nx;
    logic                          w_close;
    logic signed [PRECISION-1:0]   w_min_nx;
    logic signed [PRECISION-1:0]   w_max_nx;
    logic [FW-1:0]                 w_din;
    logic [FW-1:0]                 w_dout;
    logic                          w_full;
    logic                          w_empty;
    logic                          w_pop;
    logic                          w_drop;

    assign w_accept = en && in_valid;
    // cnt == 0 in ACCUM means the previous window just closed; the next sample opens a new one.
    assign w_first  = (r_state == ST_IDLE) || (r_cnt == '0);
    assign w_len_in = (decim_log2 > MAX_L) ? MAX_L : decim_log2;
    assign w_len    = w_first ? w_len_in : r_len;
    assign w_cnt_nx = w_first ? CW'(1) : r_cnt + CW'(1);
    assign w_close  = w_accept && (w_cnt_nx == (CW'(1) << w_len));
    assign w_min_nx = (w_first || (x < r_min)) ? x : r_min;
    assign w_max_nx = (w_first || (x > r_max)) ? x : r_max;

`ifdef MINMAX_DECIM_AVG_EN
    logic signed [SW-1:0]          r_sum;
    logic signed [SW-1:0]          w_x_ext;
    logic signed [SW-1:0]          w_sum_nx;
    logic signed [PRECISION-1:0]   w_avg;

    assign w_x_ext  = $signed({{MAX_LOG2{x[PRECISION-1]}}, x});
    assign w_sum_nx = w_first ? w_x_ext : r_sum + w_x_ext;
    assign w_avg    = PRECISION'(w_sum_nx >>> w_len);
    assign w_din    = {w_min_nx, w_max_nx, w_avg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= w_sum_nx;
        end
    end
`else
    assign w_din    = {w_min_nx, w_max_nx};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nx = ST_ACCUM;
            ST_ACCUM: if (!en)      w_state_nx = ST_IDLE;
            default:                w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_len <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (!en) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            r_cnt <= w_close ? '0 : w_cnt_nx;
            r_min <= w_min_nx;
            r_max <= w_max_nx;
            if (w_first) begin
                r_len <= w_len_in;
            end
        end
    end

    assign w_pop  = !w_empty && out_ready;
    assign w_drop = w_close && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    skid_fifo2 #(
        .W (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_close),
        .din   (w_din),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign overrun   = r_overrun;
`ifdef MINMAX_DECIM_AVG_EN
    assign y_min     = w_dout[3*PRECISION-1:2*PRECISION];
    assign y_max     = w_dout[2*PRECISION-1:PRECISION];
    assign y_avg     = w_dout[PRECISION-1:0];
`else
    assign y_min     = w_dout[2*PRECISION-1:PRECISION];
    assign y_max     = w_dout[PRECISION-1:0];
`endif

endmodule

// File: tb/tb_minmax_decimator.sv
// tb/tb_minmax_decimator.sv - randomized and directed bench for minmax_decimator
module tb_minmax_decimator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [3:0]         decim_log2;
    logic               in_valid;
    logic signed [15:0] x;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] y_min;
    logic signed [15:0] y_max;
`ifdef MINMAX_DECIM_AVG_EN
    logic signed [15:0] y_avg;
`endif
    logic               overrun;
    logic               clear_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    int win[$];
    int win_len;
    int q_min[$];
    int q_max[$];
    int q_avg[$];
    bit m_ovr;

    always #5 clk = ~clk;

    minmax_decimator u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .decim_log2    (decim_log2),
        .in_valid      (in_valid),
        .x             (x),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .y_min         (y_min),
        .y_max         (y_max),
`ifdef MINMAX_DECIM_AVG_EN
        .y_avg         (y_avg),
`endif
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        win.delete();
        q_min.delete();
        q_max.delete();
        q_avg.delete();
        m_ovr = 1'b0;
    endfunction

    task automatic model_edge(input bit e, input bit iv, input int dl, input int xv,
                              input bit rdy, input bit clr);
        bit full_pre;
        bit pop;
        bit push;
        bit set_ovr;
        int mn, mx, sum, av;
        full_pre = (q_min.size() == 2);
        pop      = (q_min.size() > 0) && rdy;
        push     = 1'b0;
        set_ovr  = 1'b0;
        mn = 0; mx = 0; av = 0;
        if (e && iv) begin
            if (win.size() == 0) win_len = 1 << ((dl > 8) ? 8 : dl);
            win.push_back(xv);
            if (win.size() == win_len) begin
                mn  = win[0];
                mx  = win[0];
                sum = 0;
                foreach (win[i]) begin
                    if (win[i] < mn) mn = win[i];
                    if (win[i] > mx) mx = win[i];
                    sum += win[i];
                end
                av = sum / win_len;
                if ((sum % win_len) != 0 && sum < 0) av--;
                push = 1'b1;
                win.delete();
            end
        end else if (!e) begin
            win.delete();
        end
        if (pop) begin
            void'(q_min.pop_front());
            void'(q_max.pop_front());
            void'(q_avg.pop_front());
        end
        if (push) begin
            if (full_pre && !pop) begin
                set_ovr = 1'b1;
            end else begin
                q_min.push_back(mn);
                q_max.push_back(mx);
                q_avg.push_back(av);
            end
        end
        if (set_ovr) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic compare_outputs();
        check_eq("out_valid", int'(out_valid), int'(q_min.size() > 0));
        if (q_min.size() > 0) begin
            check_eq("y_min", int'(y_min), q_min[0]);
            check_eq("y_max", int'(y_max), q_max[0]);
`ifdef MINMAX_DECIM_AVG_EN
            check_eq("y_avg", int'(y_avg), q_avg[0]);
`endif
        end
        check_eq("overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic step(input bit e, input bit iv, input int dl, input int xv,
                        input bit rdy, input bit clr);
        compare_outputs();
        en            = e;
        in_valid      = iv;
        decim_log2    = 4'(dl);
        x             = 16'(xv);
        out_ready     = rdy;
        clear_overrun = clr;
        @(posedge clk);
        model_edge(e, iv, dl, xv, rdy, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_y_min", int'(y_min), 0);
        check_eq("rst_y_max", int'(y_max), 0);
`ifdef MINMAX_DECIM_AVG_EN
        check_eq("rst_y_avg", int'(y_avg), 0);
`endif
        check_eq("rst_overrun", int'(overrun), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic signed [15:0] rx;
        int dl;
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; decim_log2 = '0;
        x = '0; out_ready = 1'b0; clear_overrun = 1'b0;
        @(negedge clk);
        do_reset();

        // Window of 4
        step(1, 1, 2, 3, 1, 0);
        step(1, 1, 2, -5, 1, 0);
        step(1, 1, 2, 7, 1, 0);
        step(1, 1, 2, 0, 1, 0);
        check_eq("w4_valid", int'(out_valid), 1);
        check_eq("w4_min", int'(y_min), -5);
        check_eq("w4_max", int'(y_max), 7);
`ifdef MINMAX_DECIM_AVG_EN
        check_eq("w4_avg", int'(y_avg), 1);
`endif
        check_eq("w4_overrun", int'(overrun), 0);
        step(1, 0, 2, 0, 1, 0);

        // Pass-through
        step(1, 1, 0, 1, 1, 0);
        check_eq("pt_first", int'(y_max), 1);
        step(1, 1, 0, 0, 1, 0);
        check_eq("pt_second_valid", int'(out_valid), 1);
        check_eq("pt_second", int'(y_min), 0);
        step(1, 0, 0, 0, 1, 0);

        // Back-pressure and overrun
        step(1, 1, 0, 10, 0, 0);
        step(1, 1, 0, 20, 0, 0);
        step(1, 1, 0, 30, 0, 0);
        check_eq("bp_overrun", int'(overrun), 1);
        check_eq("bp_head", int'(y_min), 10);
        step(1, 0, 0, 0, 1, 0);
        check_eq("bp_second", int'(y_min), 20);
        step(1, 0, 0, 0, 1, 0);
        check_eq("bp_drained", int'(out_valid), 0);
        step(1, 0, 0, 0, 1, 1);
        check_eq("bp_cleared", int'(overrun), 0);

        // Push and pop while full
        step(1, 1, 0, 40, 0, 0);
        step(1, 1, 0, 50, 0, 0);
        step(1, 1, 0, 60, 1, 0);
        check_eq("pp_overrun", int'(overrun), 0);
        check_eq("pp_head", int'(y_min), 50);
        step(1, 0, 0, 0, 1, 0);
        check_eq("pp_tail", int'(y_max), 60);
        step(1, 0, 0, 0, 1, 0);

        // Abort mid-window
        step(1, 1, 2, 100, 1, 0);
        step(1, 1, 2, -100, 1, 0);
        step(0, 1, 2, 999, 1, 0);
        check_eq("abort_no_out", int'(out_valid), 0);
        step(1, 1, 2, 5, 1, 0);
        step(1, 1, 2, -3, 1, 0);
        step(1, 1, 2, 9, 1, 0);
        check_eq("abort_partial", int'(out_valid), 0);
        step(1, 1, 2, 2, 1, 0);
        check_eq("abort_min", int'(y_min), -3);
        check_eq("abort_max", int'(y_max), 9);
        step(1, 0, 2, 0, 1, 0);

        // Reset mid-window with a pending result
        step(1, 1, 0, 77, 0, 0);
        step(1, 1, 2, 1, 0, 0);
        step(1, 1, 2, 2, 0, 0);
        do_reset();

        // Extremes with clamped exponent
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 15, (i % 2 == 0) ? -32768 : 32767, 1, 0);
        end
        check_eq("ext_valid", int'(out_valid), 1);
        check_eq("ext_min", int'(y_min), -32768);
        check_eq("ext_max", int'(y_max), 32767);
`ifdef MINMAX_DECIM_AVG_EN
        check_eq("ext_avg", int'(y_avg), -1);
`endif
        step(1, 0, 15, 0, 1, 0);

        // Randomized traffic
        dl = 1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                dl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15))
                                                 : int'($urandom_range(0, 3));
            end
            rx = 16'($urandom);
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, dl, int'(rx),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        compare_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
